// File: rtl/cdc_hs_tx_pkg.sv
// Shared types for the 4-phase level req/ack CDC handshake endpoints.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdc_hs_tx_pkg;

    // Default depth of a level synchronizer; two flops is the minimum safe depth.
    localparam int SYNC_STAGE_DEF = 2;

    // Handshake FSM states, shared with the receiver endpoint.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } hs_state_e;

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Local stream input plus cross-domain req/ack/data bus of the handshake source.
// Latency: n/a (wiring only).
// Backpressure: in_rdy from the slave throttles in_vld from the master.
interface cdc_hs_tx_if #(
    parameter int DWIDTH = 8
);
    logic              in_vld;
    logic              in_rdy;
    logic [DWIDTH-1:0] din;
    logic              req_o;
    logic [DWIDTH-1:0] data_o;
    logic              ack_i;

    // Producer/remote view: drives words and the remote acknowledge.
    modport master (
        output in_vld,
        output din,
        output ack_i,
        input  in_rdy,
        input  req_o,
        input  data_o
    );

    // Handshake source view.
    modport slave (
        input  in_vld,
        input  din,
        input  ack_i,
        output in_rdy,
        output req_o,
        output data_o
    );
endinterface

// File: rtl/cdc_hs_tx_sync_level.sv
// Multi-flop synchronizer for a slow level signal crossing into clk_i.
// Latency: SYNC_STAGE clk_i edges from a stable input level to the output.
// Backpressure: none.
module sync_level
    import cdc_hs_tx_pkg::*;
#(
    parameter int SYNC_STAGE = SYNC_STAGE_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_lvl,
    output logic sync_lvl
);

    logic [SYNC_STAGE-1:0] sync_sr;

    // Shift the asynchronous level through the flop chain; reset to low.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_sr <= '0;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGE-2:0], async_lvl};
        end
    end

    assign sync_lvl = sync_sr[SYNC_STAGE-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source endpoint of a 4-phase level req/ack CDC handshake with a 2-entry input buffer.
// Latency: push at edge N into idle block -> data_o at N+1, req_o rises at N+2.
// Backpressure: in_rdy drops while both buffer entries are held.
module cdc_hs_tx
    import cdc_hs_tx_pkg::*;
#(
    parameter int               DWIDTH     = 8,
    parameter int               SYNC_STAGE = SYNC_STAGE_DEF,
    parameter int               TMO_W      = 16,
    parameter logic [TMO_W-1:0] TMO_CYC    = TMO_W'(16'hFFFF),
    parameter int               CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    cdc_hs_tx_if.slave       hs,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    hs_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              ack_s;

    logic [DWIDTH-1:0] buf_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_cnt;
    logic              buf_empty;
    logic              buf_full;
    logic              push;
    logic              pop;

    logic              tmo_run;
    logic              tmo_hit;
    logic              cnt_inc;

    sync_level #(
        .SYNC_STAGE (SYNC_STAGE)
    ) u_ack_sync (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .async_lvl (hs.ack_i),
        .sync_lvl  (ack_s)
    );

    assign buf_empty = (buf_cnt == 2'd0);
    assign buf_full  = (buf_cnt == 2'd2);
    assign push      = hs.in_vld & ~buf_full;

    assign hs.in_rdy = ~buf_full;
    assign hs.req_o  = req_q;
    assign hs.data_o = data_q;
    assign busy      = (state_q != IDLE) | ~buf_empty;

    // Two-entry FIFO; push and pop may coincide at count 1 without loss.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (push) begin
                buf_mem[wr_ptr] <= hs.din;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Handshake next-state: load word, raise req, wait ack high, wait ack low.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        tmo_run = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (!buf_empty) begin
                    pop     = 1'b1;
                    data_d  = buf_mem[rd_ptr];
                    state_d = LOAD;
                end
            end
            LOAD: begin
                req_d   = 1'b1;
                tmo_d   = '0;
                state_d = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = REQ_LO;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    cnt_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (tmo_run && (tmo_q != '1)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Fire once when the phase counter first reaches the limit, so a clear sticks.
    assign tmo_hit = tmo_run && (TMO_CYC != '0) && (tmo_d == TMO_CYC) && (tmo_q != TMO_CYC);

    // Handshake state, launched word, request level and phase timer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    // Sticky timeout flag (set beats clear) and wrapping transfer counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            timeout_err <= 1'b0;
            xfer_cnt    <= '0;
        end else begin
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
            if (cnt_inc) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with a delayed-ack remote model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cdc_hs_tx;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [15:0] xfer_cnt;

    cdc_hs_tx_if #(.DWIDTH(8)) hs();

    cdc_hs_tx #(
        .DWIDTH     (8),
        .SYNC_STAGE (2),
        .TMO_W      (16),
        .TMO_CYC    (16'd10),
        .CNT_W      (16)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .hs          (hs),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .xfer_cnt    (xfer_cnt)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        hs.in_vld = 1'b1;
        hs.din    = d;
        step();
        hs.in_vld = 1'b0;
    endtask

    task automatic wait_req(input logic lvl, input int budget, input string tag, output int k);
        k = 0;
        while (hs.req_o !== lvl && k < budget) begin
            step();
            k++;
        end
        chk(tag, hs.req_o, lvl);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            step();
            k++;
        end
        chk(tag, busy, 1'b0);
    endtask

    // Remote receiver: in auto mode ack_i follows req_o three cycles later.
    logic       auto_ack = 1'b0;
    logic       manual_ack = 1'b0;
    logic [3:0] req_hist = 4'd0;
    initial begin
        hs.ack_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            req_hist = {req_hist[2:0], hs.req_o};
            hs.ack_i = auto_ack ? req_hist[3] : manual_ack;
        end
    end

    // Record each launched word and flag any data_o change around an open request.
    logic [7:0] launched[$];
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = 8'd0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                prev_req  = 1'b0;
                prev_data = 8'd0;
            end else begin
                if (hs.req_o && !prev_req) launched.push_back(hs.data_o);
                if (hs.data_o !== prev_data) chk("data_hold", {31'd0, prev_req | hs.req_o}, 32'd0);
                prev_req  = hs.req_o;
                prev_data = hs.data_o;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int k;
        int n0;
        hs.in_vld = 1'b0;
        hs.din    = 8'd0;
        step(3);

        chk("rst_req",  hs.req_o, 0);
        chk("rst_data", hs.data_o, 0);
        chk("rst_rdy",  hs.in_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err",  timeout_err, 0);
        chk("rst_cnt",  xfer_cnt, 0);
        rstn_i   = 1'b1;
        auto_ack = 1'b1;
        step(2);

        // Single word.
        push_word(8'hA5);
        chk("sw_busy", busy, 1);
        chk("sw_req_n", hs.req_o, 0);
        step();
        chk("sw_data", hs.data_o, 8'hA5);
        chk("sw_req_n1", hs.req_o, 0);
        step();
        chk("sw_req_rise", hs.req_o, 1);
        wait_req(1'b0, 20, "sw_req_fall", k);
        chk("sw_fall_lat", k, 6);
        chk("sw_ack_at_fall", hs.ack_i, 1);
        wait_idle(30, "sw_idle");
        chk("sw_xfer", xfer_cnt, 1);
        chk("sw_err", timeout_err, 0);
        chk("sw_rdy", hs.in_rdy, 1);

        // Back-to-back words.
        n0 = launched.size();
        hs.in_vld = 1'b1;
        hs.din = 8'h11;
        step();
        chk("b2b_rdy1", hs.in_rdy, 1);
        hs.din = 8'h22;
        step();
        chk("b2b_rdy2", hs.in_rdy, 1);
        hs.din = 8'h33;
        step();
        hs.in_vld = 1'b0;
        chk("b2b_full", hs.in_rdy, 0);
        step();
        chk("b2b_hold_full", hs.in_rdy, 0);
        k = 0;
        while (hs.data_o !== 8'h22 && k < 60) begin
            step();
            k++;
        end
        chk("b2b_pop22", hs.data_o, 8'h22);
        chk("b2b_rdy_after", hs.in_rdy, 1);
        wait_idle(100, "b2b_idle");
        chk("b2b_xfer", xfer_cnt, 4);
        chk("b2b_w0", launched[n0], 8'h11);
        chk("b2b_w1", launched[n0+1], 8'h22);
        chk("b2b_w2", launched[n0+2], 8'h33);

        // Push and pop on the same edge at count 1.
        n0 = launched.size();
        push_word(8'h50);
        wait_req(1'b1, 5, "sp_req50", k);
        push_word(8'h55);
        k = 0;
        while (xfer_cnt !== 16'd5 && k < 50) begin
            step();
            k++;
        end
        chk("sp_x50", xfer_cnt, 5);
        push_word(8'h44);
        chk("sp_data55", hs.data_o, 8'h55);
        chk("sp_rdy", hs.in_rdy, 1);
        push_word(8'h66);
        chk("sp_full", hs.in_rdy, 0);
        wait_idle(150, "sp_idle");
        chk("sp_xfer", xfer_cnt, 8);
        chk("sp_w0", launched[n0], 8'h50);
        chk("sp_w1", launched[n0+1], 8'h55);
        chk("sp_w2", launched[n0+2], 8'h44);
        chk("sp_w3", launched[n0+3], 8'h66);

        // Timeout with a silent remote, then a late ack.
        auto_ack   = 1'b0;
        manual_ack = 1'b0;
        step(2);
        push_word(8'h77);
        wait_req(1'b1, 5, "to_req", k);
        chk("to_err0", timeout_err, 0);
        step(9);
        chk("to_err_pre", timeout_err, 0);
        step();
        chk("to_err_set", timeout_err, 1);
        chk("to_req_held", hs.req_o, 1);
        step(3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_clr", timeout_err, 0);
        chk("to_req_still", hs.req_o, 1);
        manual_ack = 1'b1;
        wait_req(1'b0, 10, "to_late_ack", k);
        manual_ack = 1'b0;
        wait_idle(20, "to_idle");
        chk("to_xfer", xfer_cnt, 9);
        chk("to_err_end", timeout_err, 0);

        // Ack glitch while idle.
        n0 = launched.size();
        manual_ack = 1'b1;
        step();
        manual_ack = 1'b0;
        step(10);
        chk("gl_req", hs.req_o, 0);
        chk("gl_xfer", xfer_cnt, 9);
        chk("gl_busy", busy, 0);
        chk("gl_launch", launched.size(), n0);
        auto_ack = 1'b1;
        push_word(8'h99);
        wait_idle(40, "gl_idle");
        chk("gl_after_xfer", xfer_cnt, 10);
        chk("gl_after_word", launched[n0], 8'h99);

        // Reset in the middle of a handshake with a full buffer.
        auto_ack = 1'b0;
        step(2);
        push_word(8'hC1);
        wait_req(1'b1, 5, "rm_req", k);
        push_word(8'hC2);
        push_word(8'hC3);
        chk("rm_full", hs.in_rdy, 0);
        step(2);
        #1;
        rstn_i = 1'b0;
        #1;
        chk("rm_req", hs.req_o, 0);
        chk("rm_rdy", hs.in_rdy, 1);
        chk("rm_xfer", xfer_cnt, 0);
        chk("rm_busy", busy, 0);
        chk("rm_data", hs.data_o, 0);
        step(2);
        rstn_i = 1'b1;
        step(3);
        chk("rm_post_busy", busy, 0);
        chk("rm_post_req", hs.req_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
Source-side endpoint of the 4-phase level req/ack CDC handshake, clocked entirely in clk_i.
- Accepts words from a local valid/ready stream into a 2-entry buffer.
- Launches each word on a held data bus with a level request, then waits for the synchronized acknowledge from the remote receiver endpoint.
- Provides a transfer counter and a sticky handshake-timeout flag for debug.

Parameters:
DWIDTH, 8, data word width
SYNC_STAGE, 2, flop stages on the ack_i synchronizer (>=2)
TMO_W, 16, width of timeout counter
TMO_CYC, 16'hFFFF, clk_i cycles in a handshake phase before timeout_err sets; 0 disables timeout
CNT_W, 16, width of completed-transfer counter

Ports:
clk_i  in  1  source clock
rstn_i  in  1  asynchronous active-low reset
in_vld  in  1  local word valid
in_rdy  out  1  buffer can accept; push = in_vld & in_rdy
din  in  DWIDTH  local word
req_o  out  1  level request to remote domain, registered
data_o  out  DWIDTH  launched word, registered, stable while handshake open
ack_i  in  1  remote acknowledge level, asynchronous to clk_i
busy  out  1  handshake open or buffer non-empty
timeout_err  out  1  sticky: a phase exceeded TMO_CYC cycles
err_clr  in  1  1-cycle pulse, clears timeout_err
xfer_cnt  out  CNT_W  completed handshakes, wraps

Behaviour:
- Reset: req_o=0, data_o=0, timeout_err=0, xfer_cnt=0, buffer empty, FSM=IDLE. After reset, in_rdy=1 and busy=0.
- Reset mid-handshake drops req_o immediately. The remote side must be reset together with this block; no recovery protocol.
- Buffer: 2 entries, FIFO order.
  - in_rdy = !full.
  - Push and pop in the same cycle at count 1: count stays 1, no data loss.
  - Push is never accepted when full.
- ack_s: ack_i passed through SYNC_STAGE flops (reset 0). The FSM uses only ack_s.
- FSM states: IDLE, LOAD, REQ_HI, REQ_LO.
  - IDLE: if buffer non-empty, pop the head into data_o and go to LOAD.
  - LOAD: data_o already stable; set req_o=1 and go to REQ_HI. This guarantees data settles at least one clk_i cycle before req rises.
  - REQ_HI: hold req_o=1 until ack_s=1, then set req_o=0 and go to REQ_LO.
  - REQ_LO: hold req_o=0 until ack_s=0. Then increment xfer_cnt (wraps at 2^CNT_W) and go to IDLE.
- data_o changes only on the IDLE->LOAD transition. It is held unchanged through LOAD, REQ_HI and REQ_LO.
- Latency:
  - Word pushed at edge N into an empty buffer with FSM in IDLE: data_o updates at edge N+1, req_o rises at edge N+2.
  - Back-to-back words: next data_o loads on the edge after REQ_LO exits.
  - Minimum cycle per word = 2 + two ack_s propagation delays.
- Timeout counter:
  - Clears on entry to REQ_HI and REQ_LO; counts every cycle in those states; saturates at its maximum.
  - When it reaches TMO_CYC (TMO_CYC != 0), timeout_err sets.
  - The handshake is never aborted; the FSM keeps waiting.
- timeout_err: set has priority over err_clr in the same cycle.
- busy = (FSM != IDLE) | !empty.
- ack_s=1 while in IDLE or LOAD is a protocol violation. It is ignored; the FSM still waits in REQ_LO for ack_s=0 only after a genuine REQ_HI phase.

Decomposition:
- Shared package: FSM state enum (IDLE, LOAD, REQ_HI, REQ_LO, 2-bit encoding) and a SYNC_STAGE_DEF=2 constant. The package is shared with the receiver endpoint.
- Sub-module: sync_level for the ack_i synchronizer, instantiated with .SYNC_STAGE(SYNC_STAGE).
- The buffer stays inline; it is only 2 entries.

Test Plan:
- Single word: push din=8'hA5 into an idle block; remote model acks 3 cycles after req_o. Required: data_o=8'hA5 one edge after push, req_o rises the edge after that, req_o drops after ack_s=1, xfer_cnt=1, busy=0 at end.
- Back-to-back: push 8'h11, 8'h22, 8'h33 on consecutive cycles. Required: in_rdy=0 after the third push only while 2 entries are held; data_o sequence 11, 22, 33; xfer_cnt=3; data_o never changes while req_o=1 or ack_s=1.
- Simultaneous push/pop: count=1 in IDLE with push of 8'h44 on the same edge as the pop. Required: count stays 1 and 8'h44 is launched next.
- Timeout: TMO_CYC=10, remote never acks. Required: timeout_err=1 after 10 cycles in REQ_HI, req_o stays 1. err_clr pulsed with no new timeout clears it. A late ack then completes the transfer normally.
- Reset mid-handshake: assert rstn_i low in REQ_HI. Required: req_o=0, in_rdy=1, xfer_cnt=0, busy=0 immediately, without waiting for a clock edge.
- Ack glitch in IDLE: pulse ack_i for 1 remote cycle while idle. Required: no req_o activity and no xfer_cnt change.
